imem_program_loader: RTL and testbench

- Writer-side counterpart to the processor's instruction memory.
- Receives a program image as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into imem from address 0 upward.
- Holds the processor in reset until the image is fully and correctly loaded. Sits between the board/bench byte source and the skeleton's imem write port and processor reset.

---
 rtl/imem_program_loader.sv | 214 +++++++++++++++++++++
 tb/tb_imem_program_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Writer-side companion to the processor instruction memory. A program image
// arrives as a byte stream over a valid/ready handshake:
//
//     LEN_HI, LEN_LO             16-bit word count N, not part of the checksum
//     4*N data bytes             big-endian words, written from address 0 upward
//     CSUM (optional)            XOR of every data byte
//
// The processor is held in reset until an image has loaded completely and
// correctly.
//
// Build option:
//     LOADER_CSUM_EN  defined   a trailing checksum byte is expected and checked
//                     undefined no checksum byte; ERR is reachable only through
//                               the length check
//
// Ports:
//     clock          rising-edge system clock
//     reset          asynchronous active-low reset
//     start          one-cycle pulse; begins a load from IDLE, DONE or ERR
//     in_valid       source has a byte on in_data
//     in_data        stream byte
//     in_ready       loader accepts in_data this cycle
//     address_imem   imem write word address
//     data_imem      imem write data
//     wren_imem      imem write enable, one cycle per word
//     proc_reset     active-high processor reset; high until a successful load
//     busy           high while a load is in progress
//     done           high once the image has loaded
//     error          high after a rejected image
//     words_loaded   number of words written in the current load
// -----------------------------------------------------------------------------
module imem_program_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] address_imem,
    output logic [31:0]           data_imem,
    output logic                  wren_imem,
    output logic                  proc_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal word count: the full imem capacity.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           len_hi_q;
    logic [LEN_WIDTH-1:0] length_q;
    logic [1:0]           byte_idx_q;
    logic [23:0]          word_acc_q;
`ifdef LOADER_CSUM_EN
    logic [7:0]           csum_q;
`endif

    logic                 accept;
    logic                 load_begin;
    logic                 last_word;
    logic [15:0]          len_full;

    // Header length as it becomes complete on the LEN_LO byte.
    assign len_full   = {len_hi_q, in_data};
    assign last_word  = (words_loaded + LEN_WIDTH'(1)) == length_q;
    assign load_begin = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    // In the checksum-less build the final write lands in the first DONE
    // cycle, so the processor is released only once that write has gone out.
    assign proc_reset = !(state_q == S_DONE && !wren_imem);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (33'(len_full) > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
`ifdef LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && byte_idx_q == 2'd3 && last_word) begin
`ifdef LOADER_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
`ifdef LOADER_CSUM_EN
                if (in_valid) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
`else
                state_d = S_ERR;
`endif
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Byte assembly, checksum and the imem write port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_hi_q     <= '0;
            length_q     <= '0;
            byte_idx_q   <= '0;
            word_acc_q   <= '0;
`ifdef LOADER_CSUM_EN
            csum_q       <= '0;
`endif
            wren_imem    <= 1'b0;
            address_imem <= '0;
            data_imem    <= '0;
            words_loaded <= '0;
        end else begin
            wren_imem <= 1'b0;
            if (load_begin) begin
                words_loaded <= '0;
                byte_idx_q   <= '0;
`ifdef LOADER_CSUM_EN
                csum_q       <= '0;
`endif
            end
            if (accept) begin
                case (state_q)
                    S_LEN_HI: len_hi_q <= in_data;
                    S_LEN_LO: length_q <= LEN_WIDTH'(len_full);
                    S_DATA: begin
                        word_acc_q <= {word_acc_q[15:0], in_data};
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CSUM_EN
                        csum_q     <= csum_q ^ in_data;
`endif
                        // Fourth byte completes the word: write it at the
                        // current count and advance the count on the same edge.
                        if (byte_idx_q == 2'd3) begin
                            wren_imem    <= 1'b1;
                            address_imem <= words_loaded[ADDR_WIDTH-1:0];
                            data_imem    <= {word_acc_q, in_data};
                            words_loaded <= words_loaded + LEN_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    localparam int AW = 12;
    localparam int LW = 16;
    localparam int CAP = 1 << AW;

    logic          clock;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [AW-1:0] address_imem;
    logic [31:0]   data_imem;
    logic          wren_imem;
    logic          proc_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [LW-1:0] words_loaded;

    imem_program_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .address_imem (address_imem),
        .data_imem    (data_imem),
        .wren_imem    (wren_imem),
        .proc_reset   (proc_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observed imem writes, {address, data}, and proc_reset-during-load events.
    logic [AW+31:0] wr_q[$];
    int             pr_violations = 0;

    always @(negedge clock) begin
        if (wren_imem) wr_q.push_back({address_imem, data_imem});
        if (busy && !proc_reset) pr_violations++;
    end

    // Reference model: image bytes and the outcome they should produce.
    logic [7:0]  stream[$];
    logic [31:0] exp_words[$];
    bit          exp_done;
    bit          exp_error;
    int          exp_wl;

    task automatic make_image(input logic [15:0] n, input logic [31:0] words[$], input bit bad_csum);
        logic [7:0] csum;
        stream    = {};
        exp_words = {};
        csum      = 8'h00;
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        if (int'(n) > CAP) begin
            exp_error = 1'b1;
            exp_done  = 1'b0;
            exp_wl    = 0;
        end else begin
            foreach (words[i]) begin
                exp_words.push_back(words[i]);
                for (int b = 3; b >= 0; b--) begin
                    stream.push_back(words[i][8*b +: 8]);
                    csum = csum ^ words[i][8*b +: 8];
                end
            end
            exp_wl = int'(n);
`ifdef LOADER_CSUM_EN
            stream.push_back(bad_csum ? (csum ^ 8'h0F) : csum);
            exp_error = bad_csum;
            exp_done  = !bad_csum;
`else
            exp_error = 1'b0;
            exp_done  = 1'b1;
`endif
        end
    endtask

    // mode 0: in_valid continuous, 1: random gaps, 2: toggle every cycle.
    task automatic drive_stream(input int mode, input bit poke_start);
        bit tog;
        tog = 1'b0;
        foreach (stream[i]) begin
            bit sent;
            int budget;
            sent   = 1'b0;
            budget = 0;
            while (!sent) begin
                bit v;
                @(negedge clock);
                tog = !tog;
                case (mode)
                    0:       v = 1'b1;
                    1:       v = 1'($urandom_range(0, 1));
                    default: v = tog;
                endcase
                in_valid = v;
                in_data  = v ? stream[i] : 8'($urandom);
                // start is only raised while a load is in progress.
                start    = poke_start && busy && ($urandom_range(0, 2) == 0);
                if (v && in_ready) begin
                    sent = 1'b1;
                end else if (++budget > 60) begin
                    check("in_ready_timeout", 64'(in_ready), 64'(1));
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_wren"}, 64'(wren_imem), 64'(0));
        check({tag, "_addr"}, 64'(address_imem), 64'(0));
        check({tag, "_data"}, 64'(data_imem), 64'(0));
        check({tag, "_proc_reset"}, 64'(proc_reset), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
        check({tag, "_words"}, 64'(words_loaded), 64'(0));
    endtask

    task automatic compare_result(input string tag);
        check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_words.size()));
        foreach (exp_words[i]) begin
            if (i < wr_q.size()) begin
                check({tag, "_waddr"}, 64'(wr_q[i][AW+31:32]), 64'(i));
                check({tag, "_wdata"}, 64'(wr_q[i][31:0]), 64'(exp_words[i]));
            end
        end
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_error"}, 64'(error), 64'(exp_error));
        check({tag, "_proc_reset"}, 64'(proc_reset), 64'(!exp_done));
        check({tag, "_words"}, 64'(words_loaded), 64'(exp_wl));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_pr_in_load"}, 64'(pr_violations), 64'(0));
        if (exp_error) begin
            // Bytes offered in ERR must be refused and never written.
            in_valid = 1'b1;
            repeat (4) begin
                @(negedge clock);
                in_data = 8'($urandom);
                check({tag, "_err_ready"}, 64'(in_ready), 64'(0));
            end
            in_valid = 1'b0;
            @(negedge clock);
            check({tag, "_err_nwrites"}, 64'(wr_q.size()), 64'(exp_words.size()));
            check({tag, "_err_hold"}, 64'(error), 64'(1));
        end
    endtask

    task automatic run_load(input string tag, input int mode, input bit poke_start);
        wr_q          = {};
        pr_violations = 0;
        pulse_start();
        drive_stream(mode, poke_start);
        repeat (3) @(negedge clock);
        compare_result(tag);
    endtask

    logic [31:0] w[$];

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("idle");

        // Two-word image with a correct checksum.
        w = {32'h0000_0007, 32'h0000_0008};
        make_image(16'd2, w, 1'b0);
        run_load("two_word", 0, 1'b0);

`ifdef LOADER_CSUM_EN
        // Same image, checksum byte forced to 0x00.
        make_image(16'd2, w, 1'b1);
        run_load("bad_csum", 0, 1'b0);
`endif

        // Header above capacity.
        w = {};
        make_image(16'h1001, w, 1'b0);
        run_load("too_long", 0, 1'b0);

        // Empty image.
        make_image(16'd0, w, 1'b0);
        run_load("empty", 0, 1'b0);

        // One word, in_valid toggling, start pulses while busy.
        w = {32'hDEAD_BEEF};
        make_image(16'd1, w, 1'b0);
        run_load("toggle", 2, 1'b1);

        // Reset dropped after two of four data bytes.
        pulse_start();
        stream = {8'h00, 8'h01, 8'hAA, 8'hBB};
        drive_stream(0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clock);
        reset = 1'b1;
        w = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D};
        make_image(16'd3, w, 1'b0);
        run_load("after_rst", 1, 1'b0);

        // Randomised images, back to back from DONE/ERR.
        for (int t = 0; t < 10; t++) begin
            logic [15:0] n;
            bit          bad;
            n = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(CAP + 1, 65535))
                                            : 16'($urandom_range(0, 6));
            bad = ($urandom_range(0, 3) == 0);
            w = {};
            if (int'(n) <= CAP) begin
                for (int k = 0; k < int'(n); k++) w.push_back($urandom);
            end
            make_image(n, w, bad);
            run_load("rand", int'($urandom_range(0, 2)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
